dw_weight_cache_v2: RTL and testbench

Parametrised depthwise-conv weight cache: fetches a K×K×UNIT_NUM weight tile from external memory through the shared loader arbiter and presents it to the DWC PU as one wide registered vector. Generalises kernel size, channel count and bus width, adds a load-error check and optional ping-pong banking so the next tile loads while the PU computes on the current one.

---
 rtl/dw_weight_cache_v2_pkg.sv | 27 ++
 rtl/dw_weight_cache_v2_wbank.sv | 64 ++++++
 rtl/dw_weight_cache_v2.sv | 212 +++++++++++++++++++++
 tb/tb_dw_weight_cache_v2.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_weight_cache_v2_pkg.sv
// ---------------------------------------------------------------------------
// dw_pkg : shared definitions for the depthwise-conv weight cache.
//   ADDR_W / CNT_W   : loader address and beat-counter widths
//   state_e          : loader handshake FSM states
//   calc_bpt()       : bus beats needed to cover all channels of one tap
//   calc_total_beats(): beats per full K*K tile
// ---------------------------------------------------------------------------
package dw_pkg;

    localparam int ADDR_W = 19;
    localparam int CNT_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2
    } state_e;

    function automatic int calc_bpt(input int unit_num, input int data_w, input int bus_w);
        return (unit_num * data_w) / bus_w;
    endfunction

    function automatic int calc_total_beats(input int k, input int bpt);
        return k * k * bpt;
    endfunction

endpackage

// File: rtl/dw_weight_cache_v2_wbank.sv
// ---------------------------------------------------------------------------
// dw_wbank : one weight tile bank.
//   clk        in   clock
//   wr_en_i    in   write one loader beat this cycle
//   wr_beat_i  in   index of the beat being written (selects tap and lane group)
//   wr_data_i  in   beat payload, BUS_W/DATA_W weights
//   rd_q_o     out  stored tile, packed ch*K*K*DATA_W + tap*DATA_W
//   rd_d_o     out  tile as it will be after this edge (includes the beat
//                   being written), used to commit on the same edge as the
//                   final beat
// ---------------------------------------------------------------------------
module dw_wbank
    import dw_pkg::*;
#(
    parameter int UNIT_NUM = 16,
    parameter int DATA_W   = 8,
    parameter int K        = 3,
    parameter int BUS_W    = 128
) (
    input  logic                             clk,
    input  logic                             wr_en_i,
    input  logic [CNT_W-1:0]                 wr_beat_i,
    input  logic [BUS_W-1:0]                 wr_data_i,
    output logic [UNIT_NUM*K*K*DATA_W-1:0]   rd_q_o,
    output logic [UNIT_NUM*K*K*DATA_W-1:0]   rd_d_o
);

    localparam int KK     = K * K;
    localparam int LANES  = BUS_W / DATA_W;
    localparam int BPT    = calc_bpt(UNIT_NUM, DATA_W, BUS_W);
    localparam int TILE_W = UNIT_NUM * KK * DATA_W;

    logic [TILE_W-1:0] mem_q;
    logic [TILE_W-1:0] mem_d;
    int                tap;
    int                part;

    // Beat b carries tap b/BPT; within it, lane j is channel part*LANES+j.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned (which would infer a latch); comb blocks use blocking '='.
        mem_d = mem_q;
        tap   = 0;
        part  = 0;
        if (wr_en_i) begin
            tap  = int'(wr_beat_i) / BPT;
            part = int'(wr_beat_i) % BPT;
            for (int j = 0; j < LANES; j++) begin
                mem_d[((part * LANES + j) * KK + tap) * DATA_W +: DATA_W] =
                    wr_data_i[j * DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: the storage array has no reset; it is only observed after a
    // committed load has overwritten it, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_q_o = mem_q;
    assign rd_d_o = mem_d;

endmodule

// File: rtl/dw_weight_cache_v2.sv
// ---------------------------------------------------------------------------
// dw_weight_cache_v2 : depthwise-conv weight cache. Fetches a K*K*UNIT_NUM
// tile through the loader arbiter and presents it as one registered vector.
//
// Build option: DW_WCACHE_DBUF_EN -- ping-pong banks; the next tile fills
// the shadow bank while the active one drives the output, and the consumer
// releases the active tile with weights_switch.
//
// Ports:
//   clk, rst                sync active-high reset
//   load_start, base_addr   start a tile fetch (accepted when load_ready)
//   load_ready              load_start accepted this cycle
//   load_done, load_err     one-cycle pulses after loader completion
//   weights_switch          consumer releases active tile (DBUF only)
//   weights_valid           output holds a committed tile
//   ldr_req/ldr_grant       arbiter handshake
//   ldr_base_addr/ldr_count fetch descriptor to loader
//   ldr_valid/ldr_data      loader beats
//   ldr_done_sig            loader finished
//   weights_parallel_out    tile, [ch*K*K*DATA_W + tap*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module dw_weight_cache_v2
    import dw_pkg::*;
#(
    parameter int UNIT_NUM = 16,
    parameter int DATA_W   = 8,
    parameter int K        = 3,
    parameter int BUS_W    = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_start,
    input  logic [ADDR_W-1:0]                base_addr,
    output logic                             load_ready,
    output logic                             load_done,
    output logic                             load_err,
    input  logic                             weights_switch,
    output logic                             weights_valid,
    output logic                             ldr_req,
    input  logic                             ldr_grant,
    output logic [ADDR_W-1:0]                ldr_base_addr,
    output logic [CNT_W-1:0]                 ldr_count,
    input  logic                             ldr_valid,
    input  logic [BUS_W-1:0]                 ldr_data,
    input  logic                             ldr_done_sig,
    output logic [UNIT_NUM*K*K*DATA_W-1:0]   weights_parallel_out
);

    localparam int BPT         = calc_bpt(UNIT_NUM, DATA_W, BUS_W);
    localparam int TOTAL_BEATS = calc_total_beats(K, BPT);
    localparam int TILE_W      = UNIT_NUM * K * K * DATA_W;
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if ((UNIT_NUM * DATA_W) % BUS_W != 0 || BUS_W % DATA_W != 0) begin : g_bad_bus
        $error("UNIT_NUM*DATA_W must be an integer multiple of BUS_W");
    end
    if (K < 1 || K > 7 || TOTAL_BEATS > 2047) begin : g_bad_k
        $error("K must be 1..7 and the tile must fit the beat counter");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              commit;
    logic              wr_en;
    logic              pending;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start && !pending) begin
                    state_d = REQ;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (ldr_grant) state_d = RECV;
            end
            RECV: begin
                // A beat in the same cycle as done is counted before the check.
                if (ldr_valid && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (ldr_done_sig) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (cnt_d == TOTAL_CNT) commit = 1'b1;
                    else                    err_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beats past the tile end are counted but never written.
    assign wr_en = (state_q == RECV) && ldr_valid && (cnt_q < TOTAL_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign load_ready    = (state_q == IDLE) && !pending;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign ldr_req       = (state_q == REQ);
    assign ldr_base_addr = addr_q;
    assign ldr_count     = TOTAL_CNT;

`ifdef DW_WCACHE_DBUF_EN
    logic              active_q;
    logic              pending_q;
    logic              valid_q;
    logic              swap;
    logic [TILE_W-1:0] bank0_q, bank1_q;
    logic [TILE_W-1:0] unused_bank0_d, unused_bank1_d;

    // The shadow bank (~active_q) receives beats. With no tile shown yet the
    // swap happens on its own one edge after the commit.
    assign swap = pending_q && (weights_switch || !valid_q);

    dw_wbank #(.UNIT_NUM(UNIT_NUM), .DATA_W(DATA_W), .K(K), .BUS_W(BUS_W)) u_bank0 (
        .clk       (clk),
        .wr_en_i   (wr_en && active_q),
        .wr_beat_i (cnt_q),
        .wr_data_i (ldr_data),
        .rd_q_o    (bank0_q),
        .rd_d_o    (unused_bank0_d)
    );

    dw_wbank #(.UNIT_NUM(UNIT_NUM), .DATA_W(DATA_W), .K(K), .BUS_W(BUS_W)) u_bank1 (
        .clk       (clk),
        .wr_en_i   (wr_en && !active_q),
        .wr_beat_i (cnt_q),
        .wr_data_i (ldr_data),
        .rd_q_o    (bank1_q),
        .rd_d_o    (unused_bank1_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (commit)    pending_q <= 1'b1;
            else if (swap) pending_q <= 1'b0;
            if (swap) begin
                active_q <= ~active_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign pending              = pending_q;
    assign weights_valid        = valid_q;
    assign weights_parallel_out = valid_q ? (active_q ? bank1_q : bank0_q) : '0;
`else
    logic              valid_q;
    logic [TILE_W-1:0] out_q;
    logic [TILE_W-1:0] bank_d;
    logic [TILE_W-1:0] unused_bank_q;
    logic              unused_switch;

    assign unused_switch = weights_switch;

    dw_wbank #(.UNIT_NUM(UNIT_NUM), .DATA_W(DATA_W), .K(K), .BUS_W(BUS_W)) u_bank (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_beat_i (cnt_q),
        .wr_data_i (ldr_data),
        .rd_q_o    (unused_bank_q),
        .rd_d_o    (bank_d)
    );

    // Commit copies the bank's next-state view so a final beat arriving
    // with ldr_done_sig lands in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (commit) begin
            out_q   <= bank_d;
            valid_q <= 1'b1;
        end
    end

    assign pending              = 1'b0;
    assign weights_valid        = valid_q;
    assign weights_parallel_out = out_q;
`endif

endmodule

// File: tb/tb_dw_weight_cache_v2.sv
module tb_dw_weight_cache_v2;
    import dw_pkg::*;

    localparam int UNIT_NUM  = 16;
    localparam int DATA_W    = 8;
    localparam int K         = 3;
    localparam int BUS_W     = 128;
    localparam int TILE_W    = UNIT_NUM * K * K * DATA_W;
    localparam int TOTAL     = 9;
    localparam int U2_UNIT   = 32;
    localparam int U2_K      = 5;
    localparam int U2_TILE_W = U2_UNIT * U2_K * U2_K * DATA_W;
    localparam int MAXW      = U2_TILE_W;

    typedef struct {
        logic              err;
        logic [TILE_W-1:0] tile;
    } sb_t;

    sb_t exp_q[$];

    logic                clk;
    logic                rst;
    logic                load_start;
    logic [ADDR_W-1:0]   base_addr;
    logic                load_ready, load_done, load_err;
    logic                weights_switch, weights_valid;
    logic                ldr_req, ldr_grant;
    logic [ADDR_W-1:0]   ldr_base_addr;
    logic [CNT_W-1:0]    ldr_count;
    logic                ldr_valid;
    logic [BUS_W-1:0]    ldr_data;
    logic                ldr_done_sig;
    logic [TILE_W-1:0]   weights_parallel_out;

    logic                u2_load_start;
    logic [ADDR_W-1:0]   u2_base_addr;
    logic                u2_load_ready, u2_load_done, u2_load_err;
    logic                u2_weights_valid, u2_ldr_req, u2_ldr_grant;
    logic [ADDR_W-1:0]   u2_ldr_base_addr;
    logic [CNT_W-1:0]    u2_ldr_count;
    logic                u2_ldr_valid, u2_ldr_done_sig;
    logic [BUS_W-1:0]    u2_ldr_data;
    logic [U2_TILE_W-1:0] u2_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [TILE_W-1:0] cur_tile;
    logic [TILE_W-1:0] pend_tile;
    logic              cur_valid;
    logic              pend_flag;

    dw_weight_cache_v2 #(.UNIT_NUM(UNIT_NUM), .DATA_W(DATA_W), .K(K), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .load_ready(load_ready), .load_done(load_done), .load_err(load_err),
        .weights_switch(weights_switch), .weights_valid(weights_valid),
        .ldr_req(ldr_req), .ldr_grant(ldr_grant), .ldr_base_addr(ldr_base_addr),
        .ldr_count(ldr_count), .ldr_valid(ldr_valid), .ldr_data(ldr_data),
        .ldr_done_sig(ldr_done_sig), .weights_parallel_out(weights_parallel_out)
    );

    dw_weight_cache_v2 #(.UNIT_NUM(U2_UNIT), .DATA_W(DATA_W), .K(U2_K), .BUS_W(BUS_W)) dut2 (
        .clk(clk), .rst(rst), .load_start(u2_load_start), .base_addr(u2_base_addr),
        .load_ready(u2_load_ready), .load_done(u2_load_done), .load_err(u2_load_err),
        .weights_switch(1'b0), .weights_valid(u2_weights_valid),
        .ldr_req(u2_ldr_req), .ldr_grant(u2_ldr_grant), .ldr_base_addr(u2_ldr_base_addr),
        .ldr_count(u2_ldr_count), .ldr_valid(u2_ldr_valid), .ldr_data(u2_ldr_data),
        .ldr_done_sig(u2_ldr_done_sig), .weights_parallel_out(u2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_tile(input string tag, input logic [MAXW-1:0] obs, input logic [MAXW-1:0] exp);
        int first;
        logic [7:0] ob, eb;
        first = -1;
        ob = '0;
        eb = '0;
        for (int i = 0; i < MAXW / 8; i++) begin
            if (first < 0 && obs[i*8 +: 8] !== exp[i*8 +: 8]) begin
                first = i;
                ob = obs[i*8 +: 8];
                eb = exp[i*8 +: 8];
            end
        end
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: first differing byte %0d observed 0x%0h expected 0x%0h", tag, first, ob, eb);
    endtask

    function automatic logic [7:0] beat_byte(input int seed, input int b, input int j);
        return 8'((seed + b * 16 + j) & 255);
    endfunction

    function automatic logic [BUS_W-1:0] beat_vec(input int seed, input int b);
        logic [BUS_W-1:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = beat_byte(seed, b, j);
        return v;
    endfunction

    // Reference packing: beat b -> tap b/bpt, lane j -> channel (b%bpt)*16+j.
    function automatic logic [MAXW-1:0] model_tile(input int seed, input int unit, input int k);
        logic [MAXW-1:0] t;
        int bpt, ch, tap;
        t = '0;
        bpt = unit / 16;
        for (int b = 0; b < k * k * bpt; b++) begin
            for (int j = 0; j < 16; j++) begin
                ch  = (b % bpt) * 16 + j;
                tap = b / bpt;
                t[(ch * k * k + tap) * 8 +: 8] = beat_byte(seed, b, j);
            end
        end
        return t;
    endfunction

    task automatic do_load(input logic [ADDR_W-1:0] addr, input int seed, input int nbeats,
                           input bit done_with_last, input bit poke_start);
        sb_t e;
        int  guard;
        logic [MAXW-1:0] full;
        bit  last;
        guard = 0;
        while (!load_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_start", load_ready, 1);
        full   = model_tile(seed, UNIT_NUM, K);
        e.err  = (nbeats != TOTAL);
        e.tile = e.err ? cur_tile : full[TILE_W-1:0];
        exp_q.push_back(e);
        load_start = 1'b1;
        base_addr  = addr;
        tick();
        load_start = 1'b0;
        check("req_after_start", ldr_req, 1);
        check("base_addr_latched", ldr_base_addr, addr);
        ldr_grant = 1'b1;
        tick();
        ldr_grant = 1'b0;
        check("req_after_grant", ldr_req, 0);
        for (int b = 0; b < nbeats; b++) begin
            last      = (b == nbeats - 1);
            ldr_valid = 1'b1;
            ldr_data  = beat_vec(seed, b);
            if (poke_start && b == 1) begin
                load_start = 1'b1;
                base_addr  = ~addr;
            end
            if (done_with_last && last) ldr_done_sig = 1'b1;
            tick();
            load_start = 1'b0;
            if (!(done_with_last && last)) begin
                check("req_low_in_recv", ldr_req, 0);
                check_tile("hold_during_recv", MAXW'(weights_parallel_out), MAXW'(cur_tile));
            end
        end
        ldr_valid = 1'b0;
        ldr_data  = '0;
        if (!done_with_last) begin
            ldr_done_sig = 1'b1;
            tick();
        end
        ldr_done_sig = 1'b0;
        e = exp_q.pop_front();
        check("load_done", load_done, 1);
        check("load_err", load_err, e.err);
        if (!e.err) begin
`ifdef DW_WCACHE_DBUF_EN
            pend_tile = e.tile;
            pend_flag = 1'b1;
`else
            cur_tile  = e.tile;
            cur_valid = 1'b1;
`endif
        end
        check("valid_at_done", weights_valid, cur_valid);
        check_tile("out_at_done", MAXW'(weights_parallel_out), MAXW'(cur_tile));
        check("ready_at_done", load_ready, pend_flag ? 0 : 1);
        check("base_addr_kept", ldr_base_addr, addr);
        tick();
        if (pend_flag && !cur_valid) begin
            cur_tile  = pend_tile;
            cur_valid = 1'b1;
            pend_flag = 1'b0;
        end
        check("done_pulse_end", load_done, 0);
        check("err_pulse_end", load_err, 0);
        check("req_idle_after", ldr_req, 0);
        check("valid_after", weights_valid, cur_valid);
        check_tile("out_after", MAXW'(weights_parallel_out), MAXW'(cur_tile));
        check("ready_after", load_ready, pend_flag ? 0 : 1);
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;      base_addr = '0;
        weights_switch = 1'b0;  ldr_grant = 1'b0;
        ldr_valid = 1'b0;       ldr_data = '0;      ldr_done_sig = 1'b0;
        u2_load_start = 1'b0;   u2_base_addr = '0;  u2_ldr_grant = 1'b0;
        u2_ldr_valid = 1'b0;    u2_ldr_data = '0;   u2_ldr_done_sig = 1'b0;
        cur_tile = '0; pend_tile = '0; cur_valid = 1'b0; pend_flag = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ldr_req", ldr_req, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_valid", weights_valid, 0);
        check_tile("rst_out", MAXW'(weights_parallel_out), '0);
        check("rst_ready", load_ready, 1);
        check("rst_base_addr", ldr_base_addr, 0);
        check("ldr_count", ldr_count, TOTAL);

        // Tile A: byte(ch,tap) = tap*16+ch, done one cycle after last beat
        do_load(19'h01234, 0, TOTAL, 1'b0, 1'b0);

`ifdef DW_WCACHE_DBUF_EN
        // Tile B waits in the shadow bank until the consumer switches
        do_load(19'h05678, 8'h80, TOTAL, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_ready_low", load_ready, 0);
        end
        check_tile("hold_out_a", MAXW'(weights_parallel_out), MAXW'(cur_tile));
        weights_switch = 1'b1;
        tick();
        weights_switch = 1'b0;
        cur_tile  = pend_tile;
        pend_flag = 1'b0;
        check_tile("out_after_switch", MAXW'(weights_parallel_out), MAXW'(cur_tile));
        check("ready_after_switch", load_ready, 1);
`else
        // Tile B with done in the same cycle as the final beat
        do_load(19'h05678, 8'h80, TOTAL, 1'b1, 1'b0);
`endif

        // Short load: error, output and valid unchanged
        do_load(19'h00F00, 8'h40, TOTAL - 1, 1'b0, 1'b0);
        // Overlong load plus load_start during RECV: error, start ignored
        do_load(19'h2AAAA, 8'h10, TOTAL + 2, 1'b0, 1'b1);

        // Switch with nothing pending is ignored
        weights_switch = 1'b1;
        tick();
        weights_switch = 1'b0;
        check_tile("switch_no_pending", MAXW'(weights_parallel_out), MAXW'(cur_tile));

        // Grant and beats outside their states are ignored
        ldr_grant = 1'b1;
        ldr_valid = 1'b1;
        ldr_data  = beat_vec(8'h33, 0);
        tick();
        ldr_grant = 1'b0;
        ldr_valid = 1'b0;
        check("stray_grant_req", ldr_req, 0);
        check("stray_grant_ready", load_ready, 1);

        // Reset in the middle of RECV
        load_start = 1'b1;
        base_addr  = 19'h1BEEF;
        tick();
        load_start = 1'b0;
        ldr_grant  = 1'b1;
        tick();
        ldr_grant  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ldr_valid = 1'b1;
            ldr_data  = beat_vec(8'h55, b);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        cur_tile = '0; pend_tile = '0; cur_valid = 1'b0; pend_flag = 1'b0;
        check("mid_rst_req", ldr_req, 0);
        check("mid_rst_ready", load_ready, 1);
        check("mid_rst_valid", weights_valid, 0);
        check_tile("mid_rst_out", MAXW'(weights_parallel_out), '0);
        check("mid_rst_base_addr", ldr_base_addr, 0);
        for (int b = 0; b < 3; b++) begin
            ldr_data     = beat_vec(8'h55, b + 4);
            ldr_done_sig = (b == 2);
            tick();
            check("stray_after_rst_done", load_done, 0);
        end
        ldr_valid    = 1'b0;
        ldr_done_sig = 1'b0;
        tick();
        check("stray_after_rst_done2", load_done, 0);
        check("stray_after_rst_valid", weights_valid, 0);

        // Fresh load completes normally after reset
        do_load(19'h7FFFF, 8'h20, TOTAL, 1'b0, 1'b0);

        // Wider configuration: 32 channels, K=5, two beats per tap
        check("u2_ldr_count", u2_ldr_count, 50);
        u2_load_start = 1'b1;
        u2_base_addr  = 19'h3ABCD;
        tick();
        u2_load_start = 1'b0;
        check("u2_req", u2_ldr_req, 1);
        u2_ldr_grant = 1'b1;
        tick();
        u2_ldr_grant = 1'b0;
        for (int b = 0; b < 50; b++) begin
            u2_ldr_valid    = 1'b1;
            u2_ldr_data     = beat_vec(0, b);
            u2_ldr_done_sig = (b == 49);
            tick();
        end
        u2_ldr_valid    = 1'b0;
        u2_ldr_done_sig = 1'b0;
        check("u2_load_done", u2_load_done, 1);
        check("u2_load_err", u2_load_err, 0);
        tick();
        check("u2_valid", u2_weights_valid, 1);
        begin
            logic [U2_TILE_W-1:0] t;
            t = u2_out;
            check("u2_ch17_tap24", t[(17 * 25 + 24) * 8 +: 8], beat_byte(0, 49, 1));
        end
        check_tile("u2_tile", MAXW'(u2_out), model_tile(0, U2_UNIT, U2_K));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
